// File: rtl/aha_reset_sequencer.sv
// aha_reset_sequencer
// Ordered reset controller driving the REQ/ACK handshake of up to
// NUM_DOMAINS reset generators. On START it raises the requests of the
// selected domains in ascending order (each waits for its ack), holds for
// HOLD_CYCLES, then drops them in descending order, again waiting per domain.
// A domain that does not answer within TIMEOUT_CYCLES is flagged and skipped.
//
// Ports:
//   CLK            clock
//   poresetn_sync  asynchronous active-low reset (already synchronous to CLK)
//   START          one-cycle sequence request, only honoured when idle
//   DOMAIN_MASK    domains taking part, captured with an accepted START
//   RST_REQ        per-domain reset request to the generators
//   RST_ACK        per-domain generator ack (asynchronous)
//   BUSY           sequence in progress, through the DONE cycle
//   DONE           one-cycle end-of-sequence pulse
//   ERR            sticky timeout flag, cleared by the next accepted START
//   ERR_DOMAIN     index of the first domain that timed out
module aha_reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   CLK,
  input  logic                   poresetn_sync,
  input  logic                   START,
  input  logic [NUM_DOMAINS-1:0] DOMAIN_MASK,
  output logic [NUM_DOMAINS-1:0] RST_REQ,
  input  logic [NUM_DOMAINS-1:0] RST_ACK,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  output logic [3:0]             ERR_DOMAIN
);

  localparam int             HCW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [3:0]     LAST_IDX  = 4'(NUM_DOMAINS - 1);
  localparam logic [15:0]    TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_A_WAIT,
    S_HOLD,
    S_RELEASE,
    S_R_WAIT,
    S_FINISH
  } state_t;

  state_t                 state;
  logic [NUM_DOMAINS-1:0] ack_meta;
  logic [NUM_DOMAINS-1:0] ack_s;
  logic [NUM_DOMAINS-1:0] mask;
  logic [NUM_DOMAINS-1:0] idx_sel;
  logic [3:0]             idx;
  logic [15:0]            tmo_cnt;
  logic [HCW-1:0]         hold_cnt;
  logic                   cur_masked;
  logic                   cur_ack;
  logic                   tmo_hit;

  // One-hot select of the current domain; avoids indexing narrow vectors
  // with the full 4-bit idx.
  assign idx_sel    = NUM_DOMAINS'(1) << idx;
  assign cur_masked = |(mask & idx_sel);
  assign cur_ack    = |(ack_s & idx_sel);
  // The counter starts at 0 on entry, so TIMEOUT_CYCLES wait cycles elapse
  // when it shows TIMEOUT_CYCLES-1.
  assign tmo_hit    = (tmo_cnt >= TMO_LAST);

  always_ff @(posedge CLK or negedge poresetn_sync) begin
    if (!poresetn_sync) begin
      ack_meta <= '0;
      ack_s    <= '0;
    end else begin
      ack_meta <= RST_ACK;
      ack_s    <= ack_meta;
    end
  end

  always_ff @(posedge CLK or negedge poresetn_sync) begin
    if (!poresetn_sync) begin
      state      <= S_IDLE;
      RST_REQ    <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      ERR_DOMAIN <= '0;
      mask       <= '0;
      idx        <= '0;
      tmo_cnt    <= '0;
      hold_cnt   <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            mask       <= DOMAIN_MASK;
            ERR        <= 1'b0;
            ERR_DOMAIN <= '0;
            idx        <= '0;
            BUSY       <= 1'b1;
            state      <= S_ASSERT;
          end
        end

        S_ASSERT: begin
          if (cur_masked) begin
            RST_REQ <= RST_REQ | idx_sel;
            tmo_cnt <= '0;
            state   <= S_A_WAIT;
          end else if (idx == LAST_IDX) begin
            hold_cnt <= '0;
            state    <= S_HOLD;
          end else begin
            idx <= idx + 4'd1;
          end
        end

        S_A_WAIT: begin
          if (cur_ack || tmo_hit) begin
            if (!cur_ack && !ERR) begin
              ERR        <= 1'b1;
              ERR_DOMAIN <= idx;
            end
            if (idx == LAST_IDX) begin
              hold_cnt <= '0;
              state    <= S_HOLD;
            end else begin
              idx   <= idx + 4'd1;
              state <= S_ASSERT;
            end
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            idx   <= LAST_IDX;
            state <= S_RELEASE;
          end else begin
            hold_cnt <= hold_cnt + HCW'(1);
          end
        end

        S_RELEASE: begin
          if (cur_masked) begin
            RST_REQ <= RST_REQ & ~idx_sel;
            tmo_cnt <= '0;
            state   <= S_R_WAIT;
          end else if (idx == 4'd0) begin
            DONE  <= 1'b1;
            state <= S_FINISH;
          end else begin
            idx <= idx - 4'd1;
          end
        end

        S_R_WAIT: begin
          if (!cur_ack || tmo_hit) begin
            if (cur_ack && !ERR) begin
              ERR        <= 1'b1;
              ERR_DOMAIN <= idx;
            end
            if (idx == 4'd0) begin
              DONE  <= 1'b1;
              state <= S_FINISH;
            end else begin
              idx   <= idx - 4'd1;
              state <= S_RELEASE;
            end
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        // DONE was raised on entry, so it is visible for exactly this cycle.
        S_FINISH: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/aha_reset_sequencer.md
Name: aha_reset_sequencer

Overview:
- Ordered reset controller that drives the REQ/ACK reset-generator handshake for up to NUM_DOMAINS reset domains.
- On a START pulse it asserts reset requests in ascending domain order, holding off each next domain until the current one acknowledges.
- It then holds all selected domains in reset for HOLD_CYCLES and releases them in descending order, again fully handshaked.
- Sits in the platform controller between software/debug reset triggers and the per-domain reset generators.

Parameters:
- NUM_DOMAINS, 4, number of reset domains (1..16).
- HOLD_CYCLES, 8, cycles spent in HOLD after the last assert ack (>=1).
- TIMEOUT_CYCLES, 255, max cycles to wait for one ack edge before flagging an error (>=4, <2^16).

Ports:
- CLK  in  1  clock.
- poresetn_sync  in  1  asynchronous, active-low reset; already synchronized to CLK.
- START  in  1  single-cycle request to run one sequence; ignored unless IDLE.
- DOMAIN_MASK  in  NUM_DOMAINS  domains to sequence; sampled on accepted START.
- RST_REQ  out  NUM_DOMAINS  per-domain reset request, to the reset generator REQ.
- RST_ACK  in  NUM_DOMAINS  per-domain ack from the generator; asynchronous, synchronized internally.
- BUSY  out  1  high from the cycle after START acceptance until the DONE cycle, inclusive.
- DONE  out  1  one-cycle pulse at sequence end.
- ERR  out  1  sticky timeout flag; cleared on the next accepted START.
- ERR_DOMAIN  out  4  index of the first domain that timed out.

Behaviour:
- Reset values: RST_REQ=0, BUSY=0, DONE=0, ERR=0, ERR_DOMAIN=0, state=IDLE, idx=0, counters=0.
- RST_ACK: each bit passes through a 2-flop synchronizer (ack_s) reset to 0. Decisions use ack_s only.
- IDLE
  - START=1 latches mask, clears ERR/ERR_DOMAIN, sets idx=0 → ASSERT.
  - DONE=0.
- ASSERT (idx ascending)
  - If mask[idx]=0: skip, 1 cycle per skipped domain.
  - Else: set RST_REQ[idx]=1, clear the timeout counter → A_WAIT.
  - After idx=NUM_DOMAINS-1 is handled → HOLD.
- A_WAIT
  - ack_s[idx]=1: idx++ → ASSERT, or → HOLD if idx was last.
  - Timeout counter reaches TIMEOUT_CYCLES: record the error (below), leave RST_REQ[idx]=1, advance as on ack.
- HOLD
  - Count HOLD_CYCLES cycles.
  - Then idx=NUM_DOMAINS-1 → RELEASE.
- RELEASE (idx descending)
  - If mask[idx]=0: skip, 1 cycle.
  - Else: RST_REQ[idx]=0, clear counter → R_WAIT.
  - After idx=0 → FINISH.
- R_WAIT
  - ack_s[idx]=0 (or timeout, recorded as an error): advance idx-- → RELEASE, or → FINISH if idx was 0.
- FINISH
  - DONE=1 for one cycle, BUSY=1 in this cycle → IDLE.
- Error recording: on the first timeout of a sequence, ERR=1 and ERR_DOMAIN=idx. Later timeouts leave ERR_DOMAIN unchanged.
- Invariants:
  - RST_REQ bits change only in ASSERT/RELEASE.
  - At most one domain is awaiting an ack at any time.
  - Unmasked RST_REQ bits are never touched.
- Boundary conditions:
  - START while BUSY: ignored, no queueing.
  - DOMAIN_MASK=0: the sequence still runs with all skips plus HOLD. DONE fires NUM_DOMAINS+HOLD_CYCLES+NUM_DOMAINS+1 cycles after START acceptance.
  - ack_s already at its target level on entering a WAIT state: advance on the next cycle (1-cycle WAIT).
  - ack glitch (ack_s drops during later waits): ignored, since only the current idx is examined.
  - poresetn_sync assertion mid-sequence: everything returns to reset values immediately. RST_REQ drops asynchronously and no DONE is produced.
- Widths: the timeout counter is 16 bits and saturates. The hold counter is clog2(HOLD_CYCLES+1) bits. idx is 4 bits. ERR_DOMAIN is 4 bits, zero-extended.

Test Plan:
1. NUM_DOMAINS=4, mask=4'b1111, model generators ack 3 cycles after REQ edges → RST_REQ rises in order 0,1,2,3 and falls in order 3,2,1,0. One DONE pulse, ERR=0, BUSY spans the whole sequence.
2. mask=4'b0101 → only RST_REQ[0] and RST_REQ[2] toggle (0 up, 2 up, 2 down, 0 down). Bits 1 and 3 stay 0 throughout.
3. Domain 1 never acks, TIMEOUT_CYCLES=16 → after 16 cycles in A_WAIT, ERR=1 and ERR_DOMAIN=1; the sequence continues and DONE still pulses. A subsequent START clears ERR.
4. mask=0, HOLD_CYCLES=8 → DONE exactly 4+8+4+1=17 cycles after the accepted START. RST_REQ stays 0.
5. START pulses repeated every cycle during a sequence → exactly one DONE per sequence. The mask captured at the first START is used; later mask changes have no effect.
6. poresetn_sync pulled low while RST_REQ=4'b0011 in A_WAIT → RST_REQ=0, BUSY=0, DONE=0 immediately. After release the block idles until a new START.
